pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_if.sv | 29 ++
 rtl/pc_sequencer.sv | 72 +++++++
 tb/tb_pc_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// pc_seq_if: control inputs and PC/RAS status outputs of the PC sequencer
interface pc_seq_if #(parameter int ADDR_W = 32);
    logic              stall;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_offset;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] pc_curr;
    logic [ADDR_W-1:0] pc_prev;
    logic              pc_valid;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;
    modport master (
        output stall, redirect_en, redirect_pc, jump_en, jump_target,
               branch_en, branch_offset, call_en, ret_en,
        input  pc_curr, pc_prev, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf
    );
    modport slave (
        input  stall, redirect_en, redirect_pc, jump_en, jump_target,
               branch_en, branch_offset, call_en, ret_en,
        output pc_curr, pc_prev, pc_valid, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with fixed-priority next-PC select and circular return-address stack
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_INC    = 4,
    parameter int                RAS_DEPTH = 4
) (
    input logic   clk,
    input logic   rst,
    pc_seq_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     top, top_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [ADDR_W-1:0] pc_inc, pc_next;
    logic              empty, full, live, do_ret, do_call, do_pop;

    // next-PC selection and stack bookkeeping; live means the update is not held by stall
    always_comb begin
        pc_inc   = bus.pc_curr + ADDR_W'(PC_INC);
        empty    = cnt == '0;
        full     = cnt == CW'(RAS_DEPTH);
        live     = !bus.redirect_en && !bus.stall;
        do_ret   = live && bus.ret_en;
        do_call  = live && !bus.ret_en && bus.call_en;
        do_pop   = do_ret && !empty;
        pc_next  = bus.redirect_en ? bus.redirect_pc :
                   bus.stall ? bus.pc_curr :
                   bus.ret_en ? (empty ? pc_inc : ras[top]) :
                   (bus.call_en || bus.jump_en) ? bus.jump_target :
                   bus.branch_en ? bus.pc_curr + bus.branch_offset : pc_inc;
        cnt_next = bus.redirect_en ? '0 :
                   do_pop ? cnt - 1'b1 :
                   (do_call && !full) ? cnt + 1'b1 : cnt;
        top_next = do_pop ? top - 1'b1 : do_call ? top + 1'b1 : top;
    end

    // registered PC, stack pointer/count, status flags and one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pc_curr   <= RESET_PC;
            bus.pc_prev   <= RESET_PC;
            bus.pc_valid  <= 1'b0;
            bus.ras_empty <= 1'b1;
            bus.ras_full  <= 1'b0;
            bus.ras_ovf   <= 1'b0;
            bus.ras_unf   <= 1'b0;
            cnt           <= '0;
            top           <= '0;
        end else begin
            bus.pc_valid  <= 1'b1;
            bus.pc_curr   <= pc_next;
            if (bus.redirect_en || !bus.stall)
                bus.pc_prev <= bus.pc_curr;
            bus.ras_empty <= cnt_next == '0;
            bus.ras_full  <= cnt_next == CW'(RAS_DEPTH);
            bus.ras_ovf   <= do_call && full;
            bus.ras_unf   <= do_ret && empty;
            cnt           <= cnt_next;
            top           <= top_next;
        end
    end

    // stack storage; a push when full lands on the oldest slot, overwriting it
    always_ff @(posedge clk) begin
        if (do_call)
            ras[top_next] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks against a queue-based reference model
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_seq_if #(.ADDR_W(32)) bus();
    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4), .RAS_DEPTH(4))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] m_pc, m_prev;
    logic        m_valid, m_ovf, m_unf;
    logic [31:0] q[$];
    int          passed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("pc_curr", bus.pc_curr, m_pc);
        chk("pc_prev", bus.pc_prev, m_prev);
        chk("pc_valid", {31'b0, bus.pc_valid}, {31'b0, m_valid});
        chk("ras_empty", {31'b0, bus.ras_empty}, {31'b0, q.size() == 0});
        chk("ras_full", {31'b0, bus.ras_full}, {31'b0, q.size() == 4});
        chk("ras_ovf", {31'b0, bus.ras_ovf}, {31'b0, m_ovf});
        chk("ras_unf", {31'b0, bus.ras_unf}, {31'b0, m_unf});
    endtask

    task automatic model_reset();
        m_pc = 0; m_prev = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
        q.delete();
    endtask

    task automatic model_edge();
        m_valid = 1; m_ovf = 0; m_unf = 0;
        if (bus.redirect_en) begin
            m_prev = m_pc; m_pc = bus.redirect_pc; q.delete();
        end else if (!bus.stall) begin
            m_prev = m_pc;
            if (bus.ret_en) begin
                if (q.size() == 0) begin m_pc = m_pc + 4; m_unf = 1; end
                else m_pc = q.pop_back();
            end else if (bus.call_en) begin
                q.push_back(m_pc + 4);
                if (q.size() > 4) begin void'(q.pop_front()); m_ovf = 1; end
                m_pc = bus.jump_target;
            end else if (bus.jump_en) m_pc = bus.jump_target;
            else if (bus.branch_en) m_pc = m_pc + bus.branch_offset;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic drv(input logic r, input logic [31:0] rpc, input logic s,
                       input logic j, input logic [31:0] jt, input logic b,
                       input logic [31:0] off, input logic c, input logic rt);
        bus.redirect_en = r; bus.redirect_pc = rpc; bus.stall = s;
        bus.jump_en = j; bus.jump_target = jt; bus.branch_en = b;
        bus.branch_offset = off; bus.call_en = c; bus.ret_en = rt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic call(input logic [31:0] t);
        drv(0, 0, 0, 0, t, 0, 0, 1, 0);
        step();
    endtask

    task automatic ret();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
    endtask

    task automatic redirect(input logic [31:0] t);
        drv(1, t, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        logic [31:0] hold_pc, hold_prev;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1 check_all();
        #6 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("seq_pc", bus.pc_curr, 32'(4 * (i + 1)));
        end
        redirect(32'h100);
        call(32'h400);
        chk("call_target", bus.pc_curr, 32'h400);
        ret();
        chk("ret_addr", bus.pc_curr, 32'h104);
        chk("ret_empty", {31'b0, bus.ras_empty}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            call(32'h1000 * (i + 1));
            if (i == 3) chk("full_after_4", {31'b0, bus.ras_full}, 32'h1);
            if (i == 4) chk("ovf_after_5", {31'b0, bus.ras_ovf}, 32'h1);
        end
        for (int i = 0; i < 5; i++) ret();
        chk("unf_after_5", {31'b0, bus.ras_unf}, 32'h1);
        call(32'h2000);
        hold_pc = bus.pc_curr; hold_prev = bus.pc_prev;
        drv(0, 0, 1, 1, 32'h5555, 0, 0, 0, 0);
        step();
        chk("stall_pc", bus.pc_curr, hold_pc);
        chk("stall_prev", bus.pc_prev, hold_prev);
        drv(1, 32'h80, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("stall_redirect", bus.pc_curr, 32'h80);
        chk("redirect_clear", {31'b0, bus.ras_empty}, 32'h1);
        redirect(32'hFFFF_FFFC);
        idle();
        chk("wrap_seq", bus.pc_curr, 32'h0);
        redirect(32'h10);
        drv(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0);
        step();
        chk("wrap_branch", bus.pc_curr, 32'h0);
        for (int i = 0; i < 4; i++) call(32'h300 + 32'(i * 16));
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        #3 rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 4) == 0,
                ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
